// File: rtl/xup_gate_sweep_ctrl_pkg.sv
// Shared definitions for the XUP gate sweep controller: reference op codes and FSM states.
package xup_gate_sweep_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_APPLY = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Codes 6 and 7 are reserved and have no reference function.
    function automatic logic op_is_defined(input logic [2:0] op);
        return (op <= 3'd5);
    endfunction

endpackage

// File: rtl/xup_gate_sweep_ctrl_ref.sv
// Combinational reference function ref(op, vec) for the gate sweep controller.
module xup_gate_ref
    import xup_gate_sweep_ctrl_pkg::*;
#(
    parameter int N_IN = 6
) (
    input  logic [2:0]      op,
    input  logic [N_IN-1:0] vec,
    output logic            exp,
    output logic            op_ok
);

    // Select the expected gate output for the latched op code.
    always_comb begin
        exp   = 1'b0;
        op_ok = op_is_defined(op);
        case (op)
            OP_AND:  exp = &vec;
            OP_OR:   exp = |vec;
            OP_NAND: exp = ~(&vec);
            OP_NOR:  exp = ~(|vec);
            OP_XOR:  exp = ^vec;
            OP_XNOR: exp = ~(^vec);
            default: exp = 1'b0;
        endcase
    end

endmodule

// File: rtl/xup_gate_sweep_ctrl.sv
// Exhaustive sweep sequencer for one N_IN-input gate under test.
// Optional feature: define XUP_SWEEP_SYNC_EN to pass gate_y through a 2-flop synchronizer.
module xup_gate_sweep_ctrl
    import xup_gate_sweep_ctrl_pkg::*;
#(
    parameter int N_IN   = 6,
    parameter int SETTLE = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    output logic [N_IN-1:0] gate_in,
    input  logic            gate_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] fail_vec,
    output logic            fail_valid
);

`ifdef XUP_SWEEP_SYNC_EN
    localparam int WAIT_LEN = SETTLE + 2;
`else
    localparam int WAIT_LEN = SETTLE;
`endif
    localparam int            CW        = $clog2(WAIT_LEN + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_LEN - 1);
    localparam logic [N_IN:0] ERR_MAX   = {1'b1, {N_IN{1'b0}}};
    localparam logic [N_IN:0] VEC_LAST  = {1'b0, {N_IN{1'b1}}};

    state_e          state_r;
    state_e          next_s;
    logic [N_IN:0]   vec_r;
    logic [CW-1:0]   settle_cnt_r;
    logic [2:0]      op_r;
    logic            exp_s;
    logic            op_ok_s;
    logic            y_cmp_s;
    logic            mismatch_s;
    logic            last_vec_s;
    logic            wait_done_s;

`ifdef XUP_SWEEP_SYNC_EN
    logic            y_meta_r;
    logic            y_sync_r;

    // Two-flop synchronizer for an asynchronous gate output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_meta_r <= 1'b0;
            y_sync_r <= 1'b0;
        end else begin
            y_meta_r <= gate_y;
            y_sync_r <= y_meta_r;
        end
    end

    assign y_cmp_s = y_sync_r;
`else
    assign y_cmp_s = gate_y;
`endif

    xup_gate_ref #(.N_IN(N_IN)) u_ref (
        .op    (op_r),
        .vec   (vec_r[N_IN-1:0]),
        .exp   (exp_s),
        .op_ok (op_ok_s)
    );

    // A reserved op has no valid reference, so every vector is a mismatch.
    assign mismatch_s  = ~op_ok_s | (y_cmp_s != exp_s);
    assign last_vec_s  = (vec_r == VEC_LAST);
    assign wait_done_s = (settle_cnt_r == WAIT_LAST);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_s = ST_APPLY;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_APPLY: next_s = ST_WAIT;
            ST_WAIT: begin
                if (wait_done_s) begin
                    next_s = ST_CHECK;
                end else begin
                    next_s = ST_WAIT;
                end
            end
            ST_CHECK: begin
                if (last_vec_s) begin
                    next_s = ST_DONE;
                end else begin
                    next_s = ST_APPLY;
                end
            end
            ST_DONE: next_s = ST_IDLE;
            default: next_s = ST_IDLE;
        endcase
    end

    // Vector/settle counters, latched op and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec_r        <= '0;
            settle_cnt_r <= '0;
            op_r         <= 3'd0;
            gate_in      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            fail_vec     <= '0;
            fail_valid   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        op_r       <= op;
                        vec_r      <= '0;
                        err_count  <= '0;
                        fail_vec   <= '0;
                        fail_valid <= 1'b0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                ST_APPLY: begin
                    gate_in      <= vec_r[N_IN-1:0];
                    settle_cnt_r <= '0;
                end
                ST_WAIT: begin
                    if (wait_done_s) begin
                        settle_cnt_r <= '0;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + CW'(1'b1);
                    end
                end
                ST_CHECK: begin
                    if (mismatch_s) begin
                        if (err_count != ERR_MAX) begin
                            err_count <= err_count + {{N_IN{1'b0}}, 1'b1};
                        end
                        if (!fail_valid) begin
                            fail_vec   <= vec_r[N_IN-1:0];
                            fail_valid <= 1'b1;
                        end
                    end
                    if (!last_vec_s) begin
                        vec_r <= vec_r + {{N_IN{1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    pass <= (err_count == '0);
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xup_gate_sweep_ctrl.sv
// Scoreboard bench for xup_gate_sweep_ctrl with a behavioural sweep model.
module tb_xup_gate_sweep_ctrl;

    localparam int N_IN   = 6;
    localparam int SETTLE = 3;
    localparam int NV     = 64;
`ifdef XUP_SWEEP_SYNC_EN
    localparam int LAT = NV * (SETTLE + 4) + 1;
`else
    localparam int LAT = NV * (SETTLE + 2) + 1;
`endif

    logic            clk;
    logic            reset;
    logic            start;
    logic [2:0]      op;
    logic [N_IN-1:0] gate_in;
    logic            gate_y;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] fail_vec;
    logic            fail_valid;

    typedef struct {
        int err;
        int fvec;
        int fvalid;
        int pass;
        int start_cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks;
    int          errors;
    int          cyc;
    int          done_cnt;
    int          mode;
    logic [5:0]  fault_v;

    xup_gate_sweep_ctrl #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .gate_in    (gate_in),
        .gate_y     (gate_y),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_vec   (fail_vec),
        .fail_valid (fail_valid)
    );

    // Gate under test: and6, stuck-at-0, stuck-at-1, or and6 with one flipped vector.
    assign gate_y = (mode == 1) ? 1'b0 :
                    (mode == 2) ? 1'b1 :
                    ((mode == 3) && (gate_in == fault_v)) ? ~(&gate_in) : (&gate_in);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks = checks + 1;
        if (act != req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Truth-table reference; -1 marks a reserved op.
    function automatic int model_ref(input int o, input int v);
        int ones;
        ones = $countones(v[5:0]);
        case (o)
            0: return (v == 63) ? 1 : 0;
            1: return (v != 0) ? 1 : 0;
            2: return (v == 63) ? 0 : 1;
            3: return (v == 0) ? 1 : 0;
            4: return ones % 2;
            5: return 1 - (ones % 2);
            default: return -1;
        endcase
    endfunction

    function automatic int model_gate(input int m, input int f, input int v);
        int a;
        a = (v == 63) ? 1 : 0;
        if (m == 1) return 0;
        if (m == 2) return 1;
        if (m == 3 && v == f) return 1 - a;
        return a;
    endfunction

    // Monitor: pop an expectation whenever the DUT signals sweep end.
    always @(negedge clk) begin
        if (!reset && done) begin
            done_cnt <= done_cnt + 1;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("err_count", int'(err_count), mon_e.err);
                check("fail_vec", int'(fail_vec), mon_e.fvec);
                check("fail_valid", int'(fail_valid), mon_e.fvalid);
                check("pass", int'(pass), mon_e.pass);
                check("done_latency", cyc - mon_e.start_cyc, LAT);
                check("busy_at_done", int'(busy), 0);
            end
        end
    end

    task automatic run_sweep(input int op_v, input int mode_v, input int fault,
                             input bit disturb, input bit done_cycle_start);
        exp_t e;
        int   base;
        int   rel;
        int   r;
        int   g;
        e.err = 0;
        e.fvec = 0;
        e.fvalid = 0;
        for (int v = 0; v < NV; v++) begin
            r = model_ref(op_v, v);
            g = model_gate(mode_v, fault, v);
            if (r < 0 || r != g) begin
                if (e.err == 0) e.fvec = v;
                e.err = e.err + 1;
                e.fvalid = 1;
            end
        end
        e.pass = (e.err == 0) ? 1 : 0;
        @(negedge clk);
        mode    = mode_v;
        fault_v = fault[5:0];
        op      = op_v[2:0];
        start   = 1'b1;
        base    = done_cnt;
        e.start_cyc = cyc + 1;
        exp_q.push_back(e);
        for (int i = 0; i < LAT + 50; i++) begin
            @(negedge clk);
            rel = cyc - e.start_cyc;
            if (rel == 50) check("busy_mid", int'(busy), 1);
            if (disturb && rel > 5 && rel < LAT - 20) begin
                start = ($urandom_range(0, 7) == 0);
                op    = 3'($urandom_range(0, 7));
            end else if (done_cycle_start && rel == LAT - 1) begin
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done_cnt != base) break;
        end
        start = 1'b0;
        check("sweep_completed", (done_cnt != base) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
        check("idle_after_done", int'(busy), 0);
    endtask

    task automatic reset_mid_sweep();
        int base;
        int sc;
        @(negedge clk);
        mode  = 2;
        op    = 3'd0;
        start = 1'b1;
        sc    = cyc + 1;
        base  = done_cnt;
        @(negedge clk);
        start = 1'b0;
        while (cyc - sc < 100) @(negedge clk);
        check("errs_before_reset", (err_count != 0) ? 1 : 0, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_gate_in", int'(gate_in), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_err_count", int'(err_count), 0);
        check("rst_fail_vec", int'(fail_vec), 0);
        check("rst_fail_valid", int'(fail_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (LAT + 20) @(negedge clk);
        check("no_done_after_abort", done_cnt - base, 0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        done_cnt = 0;
        mode     = 0;
        fault_v  = 6'd0;
        reset    = 1'b1;
        start    = 1'b0;
        op       = 3'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("init_gate_in", int'(gate_in), 0);
        check("init_busy", int'(busy), 0);
        check("init_pass", int'(pass), 0);
        check("init_err_count", int'(err_count), 0);
        check("init_fail_valid", int'(fail_valid), 0);

        run_sweep(0, 0, 0, 1'b0, 1'b0);
        run_sweep(1, 0, 0, 1'b0, 1'b0);
        run_sweep(0, 1, 0, 1'b0, 1'b0);
        run_sweep(0, 2, 0, 1'b0, 1'b0);
        reset_mid_sweep();
        run_sweep(0, 0, 0, 1'b0, 1'b1);
        run_sweep(0, 0, 0, 1'b1, 1'b0);
        run_sweep(6, 0, 0, 1'b0, 1'b0);
        run_sweep(4, 3, 37, 1'b0, 1'b0);
        repeat (8) begin
            run_sweep($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 63),
                      1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
